multicycle_sequencer: RTL and testbench

//  Multi-cycle FSM controller for the 19-bit processor. Fetches over a req/ack port, decodes the

---
 rtl/multicycle_sequencer.sv | 239 +++++++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
// Multi-cycle fetch/decode/execute controller for the 19-bit processor.
// Optional return stack enabled by defining CALL_STACK_EN.
module multicycle_sequencer #(
  parameter int PC_W    = 12,
  parameter int STACK_D = 8
) (
  input  logic            clock,
  input  logic            rst,
  output logic            instrReq,
  input  logic            instrAck,
  input  logic [18:0]     instr,
  input  logic [PC_W-1:0] pcIn,
  input  logic            zeroFlag,
  input  logic            carryFlag,
  output logic            memRead,
  output logic            memWrite,
  input  logic            memAck,
  output logic [2:0]      ALUfunction,
  output logic [1:0]      sh_roFunction,
  output logic            selectAluArg,
  output logic            selectR2,
  output logic [1:0]      selectToWrite,
  output logic            regWrite,
  output logic            enableZero,
  output logic            enableCarry,
  output logic            pcWrite,
  output logic [1:0]      pcSel,
  output logic [PC_W-1:0] stackTop,
  output logic            illegal,
  output logic [2:0]      state
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    C_ALU, C_SHIFT, C_LDM, C_STM, C_BR, C_JMP, C_JSB, C_RET, C_ILL
  } cls_t;

  state_t     cur;
  cls_t       cls;
  cls_t       ackCls;
  logic [2:0] irFunc;
  logic       fault;
  logic       decFault;
  logic       jsbFault;
  logic       retFault;
  logic       branchTaken;
  logic [1:0] execPcSel;
  logic [1:0] ackSelWr;
  logic       unusedInstr;

  function automatic cls_t classify(input logic [18:0] w);
    cls_t c;
    c = C_ILL;
    case (w[18:16])
      3'b000, 3'b001, 3'b010, 3'b011: c = C_ALU;
      3'b110: c = C_SHIFT;
      3'b100: c = (w[15:14] == 2'b00) ? C_LDM : (w[15:14] == 2'b01) ? C_STM : C_ILL;
      3'b101: c = C_BR;
      3'b111: begin
        case (w[15:14])
          2'b00:   c = C_JMP;
          2'b01:   c = C_JSB;
          2'b10:   c = C_RET;
          default: c = C_ILL;
        endcase
      end
      default: c = C_ILL;
    endcase
    return c;
  endfunction

  assign ackCls        = classify(instr);
  assign unusedInstr   = ^instr[13:0];
  assign state         = cur;
  assign ALUfunction   = irFunc;
  assign sh_roFunction = irFunc[1:0];

  always_comb begin
    ackSelWr = 2'b00;
    case (ackCls)
      C_SHIFT: ackSelWr = 2'b01;
      C_LDM:   ackSelWr = 2'b10;
      default: ackSelWr = 2'b00;
    endcase
  end

  always_comb begin
    decFault = 1'b0;
    case (cls)
      C_ILL:   decFault = 1'b1;
      C_JSB:   decFault = jsbFault;
      C_RET:   decFault = retFault;
      default: decFault = 1'b0;
    endcase
  end

  always_comb begin
    branchTaken = 1'b0;
    case (irFunc[1:0])
      2'b00:   branchTaken = zeroFlag;
      2'b01:   branchTaken = !zeroFlag;
      2'b10:   branchTaken = carryFlag;
      default: branchTaken = !carryFlag;
    endcase
  end

  always_comb begin
    execPcSel = 2'b00;
    if (!fault) begin
      case (cls)
        C_BR:         execPcSel = branchTaken ? 2'b01 : 2'b00;
        C_JMP, C_JSB: execPcSel = 2'b10;
        C_RET:        execPcSel = 2'b11;
        default:      execPcSel = 2'b00;
      endcase
    end
  end

`ifdef CALL_STACK_EN
  localparam int SP_W  = $clog2(STACK_D + 1);
  localparam int IDX_W = (STACK_D > 1) ? $clog2(STACK_D) : 1;

  logic [PC_W-1:0] stackMem [STACK_D];
  logic [SP_W-1:0] sp;

  assign jsbFault = (sp == SP_W'(STACK_D));
  assign retFault = (sp == '0);
  assign stackTop = retFault ? '0 : stackMem[IDX_W'(sp - 1'b1)];

  always_ff @(posedge clock) begin
    if (cur == EXEC && !fault && cls == C_JSB)
      stackMem[IDX_W'(sp)] <= pcIn + 1'b1;
  end

  // Push in EXEC, pop after WB so the return address is still on stackTop while the PC loads it.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst)
      sp <= '0;
    else if (cur == EXEC && !fault && cls == C_JSB)
      sp <= sp + 1'b1;
    else if (cur == WB && !fault && cls == C_RET)
      sp <= sp - 1'b1;
  end
`else
  logic unusedStack;

  assign jsbFault    = 1'b1;
  assign retFault    = 1'b1;
  assign stackTop    = '0;
  assign unusedStack = ^pcIn ^ (STACK_D != 0);
`endif

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      cur           <= FETCH;
      cls           <= C_ILL;
      irFunc        <= '0;
      fault         <= 1'b0;
      instrReq      <= 1'b0;
      memRead       <= 1'b0;
      memWrite      <= 1'b0;
      selectAluArg  <= 1'b0;
      selectR2      <= 1'b0;
      selectToWrite <= '0;
      regWrite      <= 1'b0;
      enableZero    <= 1'b0;
      enableCarry   <= 1'b0;
      pcWrite       <= 1'b0;
      pcSel         <= '0;
      illegal       <= 1'b0;
    end else begin
      enableZero  <= 1'b0;
      enableCarry <= 1'b0;
      illegal     <= 1'b0;
      case (cur)
        FETCH: begin
          if (!instrReq) begin
            instrReq <= 1'b1;
          end else if (instrAck) begin
            instrReq      <= 1'b0;
            irFunc        <= instr[16:14];
            cls           <= ackCls;
            selectAluArg  <= (instr[18:17] == 2'b00);
            selectR2      <= (ackCls != C_STM);
            selectToWrite <= ackSelWr;
            cur           <= DECODE;
          end
        end
        DECODE: begin
          fault       <= decFault;
          illegal     <= decFault;
          enableZero  <= (cls == C_ALU);
          enableCarry <= (cls == C_ALU);
          cur         <= EXEC;
        end
        EXEC: begin
          if (!fault && cls == C_LDM) begin
            memRead <= 1'b1;
            cur     <= MEM;
          end else if (!fault && cls == C_STM) begin
            memWrite <= 1'b1;
            cur      <= MEM;
          end else begin
            pcWrite  <= 1'b1;
            regWrite <= !fault && (cls == C_ALU || cls == C_SHIFT);
            pcSel    <= execPcSel;
            cur      <= WB;
          end
        end
        MEM: begin
          if (memAck) begin
            memRead  <= 1'b0;
            memWrite <= 1'b0;
            pcWrite  <= 1'b1;
            regWrite <= (cls == C_LDM);
            pcSel    <= 2'b00;
            cur      <= WB;
          end
        end
        WB: begin
          pcWrite  <= 1'b0;
          regWrite <= 1'b0;
          pcSel    <= 2'b00;
          instrReq <= 1'b1;
          cur      <= FETCH;
        end
        default: cur <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized bench for multicycle_sequencer: a transaction-level model predicts every output per cycle.
module tb_multicycle_sequencer;
  localparam int PC_W    = 12;
  localparam int STACK_D = 8;
`ifdef CALL_STACK_EN
  localparam bit HAS_STACK = 1'b1;
`else
  localparam bit HAS_STACK = 1'b0;
`endif

  localparam int C_ALU = 0, C_SHIFT = 1, C_LDM = 2, C_STM = 3, C_BR = 4,
                 C_JMP = 5, C_JSB = 6, C_RET = 7, C_ILL = 8;

  logic            clock = 1'b0;
  logic            rst = 1'b0;
  logic            instrReq, instrAck = 1'b0;
  logic [18:0]     instr = '0;
  logic [PC_W-1:0] pcIn = '0;
  logic            zeroFlag = 1'b0, carryFlag = 1'b0;
  logic            memRead, memWrite, memAck = 1'b0;
  logic [2:0]      ALUfunction;
  logic [1:0]      sh_roFunction;
  logic            selectAluArg, selectR2;
  logic [1:0]      selectToWrite;
  logic            regWrite, enableZero, enableCarry, pcWrite;
  logic [1:0]      pcSel;
  logic [PC_W-1:0] stackTop;
  logic            illegal;
  logic [2:0]      state;

  multicycle_sequencer #(.PC_W(PC_W), .STACK_D(STACK_D)) dut (
    .clock(clock), .rst(rst), .instrReq(instrReq), .instrAck(instrAck), .instr(instr),
    .pcIn(pcIn), .zeroFlag(zeroFlag), .carryFlag(carryFlag), .memRead(memRead),
    .memWrite(memWrite), .memAck(memAck), .ALUfunction(ALUfunction),
    .sh_roFunction(sh_roFunction), .selectAluArg(selectAluArg), .selectR2(selectR2),
    .selectToWrite(selectToWrite), .regWrite(regWrite), .enableZero(enableZero),
    .enableCarry(enableCarry), .pcWrite(pcWrite), .pcSel(pcSel), .stackTop(stackTop),
    .illegal(illegal), .state(state)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]      st;
    logic            req, mr, mw, ez, ec, ill, rw, pw;
    logic [1:0]      ps;
    logic            chkFn;
    logic [2:0]      fn;
    logic            chkArg, arg, chkR2, r2, chkWr;
    logic [1:0]      wr;
    logic            chkTop;
    logic [PC_W-1:0] top;
  } exp_t;

  exp_t            expQ[$];
  exp_t            cmpRec;
  logic [PC_W-1:0] stk[$];
  int checks = 0, errors = 0;
  int memReadCycles = 0, illegalPulses = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, want, $time);
    end
  endtask

  // Instruction classes straight from the opcode table.
  function automatic int category(input logic [18:0] w);
    logic [1:0] fn;
    fn = w[15:14];
    if (w[18] == 1'b0) return C_ALU;
    case (w[17:16])
      2'b10:   return C_SHIFT;
      2'b00:   return (fn == 2'd0) ? C_LDM : (fn == 2'd1) ? C_STM : C_ILL;
      2'b01:   return C_BR;
      default: return (fn == 2'd0) ? C_JMP : (fn == 2'd1) ? C_JSB : (fn == 2'd2) ? C_RET : C_ILL;
    endcase
  endfunction

  function automatic bit faulty(input int cat, input int depth);
    if (cat == C_ILL) return 1'b1;
    if (cat == C_JSB) return HAS_STACK ? (depth == STACK_D) : 1'b1;
    if (cat == C_RET) return HAS_STACK ? (depth == 0) : 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [1:0] wantPcSel(input int cat, input bit flt, input logic [1:0] fn,
                                           input logic z, input logic c);
    bit taken;
    if (flt) return 2'd0;
    case (cat)
      C_BR: begin
        taken = (fn == 2'd0) ? z : (fn == 2'd1) ? !z : (fn == 2'd2) ? c : !c;
        return taken ? 2'd1 : 2'd0;
      end
      C_JMP, C_JSB: return 2'd2;
      C_RET:        return 2'd3;
      default:      return 2'd0;
    endcase
  endfunction

  always @(negedge clock) begin
    if (memRead === 1'b1) memReadCycles++;
    if (illegal === 1'b1) illegalPulses++;
    if (expQ.size() != 0) begin
      cmpRec = expQ.pop_front();
      chk("state", state, cmpRec.st);
      chk("instrReq", instrReq, cmpRec.req);
      chk("memRead", memRead, cmpRec.mr);
      chk("memWrite", memWrite, cmpRec.mw);
      chk("enableZero", enableZero, cmpRec.ez);
      chk("enableCarry", enableCarry, cmpRec.ec);
      chk("illegal", illegal, cmpRec.ill);
      chk("regWrite", regWrite, cmpRec.rw);
      chk("pcWrite", pcWrite, cmpRec.pw);
      chk("pcSel", pcSel, cmpRec.ps);
      if (cmpRec.chkFn) begin
        chk("ALUfunction", ALUfunction, cmpRec.fn);
        chk("sh_roFunction", sh_roFunction, cmpRec.fn[1:0]);
      end
      if (cmpRec.chkArg) chk("selectAluArg", selectAluArg, cmpRec.arg);
      if (cmpRec.chkR2) chk("selectR2", selectR2, cmpRec.r2);
      if (cmpRec.chkWr) chk("selectToWrite", selectToWrite, cmpRec.wr);
      if (cmpRec.chkTop) chk("stackTop", stackTop, cmpRec.top);
    end
  end

  task automatic cyc(input exp_t e, input logic ack, input logic mack, input logic [18:0] w,
                     input logic z, input logic c);
    @(posedge clock);
    #1;
    instrAck  = ack;
    memAck    = mack;
    instr     = w;
    zeroFlag  = z;
    carryFlag = c;
    expQ.push_back(e);
  endtask

  task automatic releaseReset();
    exp_t e;
    e = '{default: '0};
    e.chkTop = 1'b1;
    @(posedge clock);
    #1;
    rst      = 1'b1;
    instrAck = 1'b1;
    memAck   = 1'b1;
    instr    = 19'($urandom);
    stk.delete();
    expQ.push_back(e);
  endtask

  task automatic runInstr(input logic [18:0] w, input logic [PC_W-1:0] pc, input int ackDelay,
                          input int memDelay, input logic ez, input logic ec, input bit abortMem);
    exp_t e;
    int   cat;
    bit   flt;
    bit   isMem;
    cat   = category(w);
    flt   = faulty(cat, stk.size());
    isMem = !flt && (cat == C_LDM || cat == C_STM);
    pcIn  = pc;
    e = '{default: '0};
    e.chkTop = 1'b1;
    e.top    = (stk.size() == 0) ? '0 : stk[$];
    e.req    = 1'b1;
    for (int i = 0; i < ackDelay; i++)
      cyc(e, 1'b0, 1'($urandom), 19'($urandom), 1'($urandom), 1'($urandom));
    cyc(e, 1'b1, 1'($urandom), w, 1'($urandom), 1'($urandom));
    e.req    = 1'b0;
    e.st     = 3'd1;
    e.chkFn  = 1'b1;
    e.fn     = w[16:14];
    e.chkArg = (cat == C_ALU);
    e.arg    = !w[17];
    e.chkR2  = (cat == C_ALU || cat == C_STM);
    e.r2     = (cat != C_STM);
    e.chkWr  = (cat == C_ALU || cat == C_SHIFT || cat == C_LDM);
    e.wr     = (cat == C_SHIFT) ? 2'd1 : (cat == C_LDM) ? 2'd2 : 2'd0;
    cyc(e, 1'($urandom), 1'($urandom), 19'($urandom), 1'($urandom), 1'($urandom));
    e.st  = 3'd2;
    e.ez  = (cat == C_ALU);
    e.ec  = (cat == C_ALU);
    e.ill = flt;
    cyc(e, 1'($urandom), 1'($urandom), 19'($urandom), ez, ec);
    e.ez  = 1'b0;
    e.ec  = 1'b0;
    e.ill = 1'b0;
    if (isMem) begin
      e.st = 3'd3;
      e.mr = (cat == C_LDM);
      e.mw = (cat == C_STM);
      if (abortMem) begin
        cyc(e, 1'($urandom), 1'b0, 19'($urandom), 1'($urandom), 1'($urandom));
        return;
      end
      for (int j = 0; j <= memDelay; j++)
        cyc(e, 1'($urandom), (j == memDelay), 19'($urandom), 1'($urandom), 1'($urandom));
      e.mr = 1'b0;
      e.mw = 1'b0;
    end
    e.st = 3'd4;
    e.pw = 1'b1;
    e.rw = !flt && (cat == C_ALU || cat == C_SHIFT || cat == C_LDM);
    e.ps = wantPcSel(cat, flt, w[15:14], ez, ec);
    if (cat == C_JSB && !flt) e.chkTop = 1'b0;
    cyc(e, 1'($urandom), 1'($urandom), 19'($urandom), 1'($urandom), 1'($urandom));
    if (!flt && cat == C_JSB) stk.push_back(pc + 1'b1);
    if (!flt && cat == C_RET) void'(stk.pop_back());
  endtask

  initial begin
    int snap;
    logic [18:0] w;

    chk("pinBzTaken", wantPcSel(C_BR, 1'b0, 2'b00, 1'b1, 1'b0), 1);
    chk("pinBzNotTaken", wantPcSel(C_BR, 1'b0, 2'b00, 1'b0, 1'b1), 0);
    chk("pinBncTaken", wantPcSel(C_BR, 1'b0, 2'b11, 1'b1, 1'b0), 1);
    chk("pinIllegal10011", faulty(category({3'b100, 2'b11, 14'h0}), 0), 1);
    chk("pinRet", wantPcSel(category({3'b111, 2'b10, 14'h0}), 1'b0, 2'b10, 1'b0, 1'b0), 3);

    #3;
    chk("rstState", state, 0);
    chk("rstInstrReq", instrReq, 0);
    chk("rstMemRead", memRead, 0);
    chk("rstMemWrite", memWrite, 0);
    chk("rstRegWrite", regWrite, 0);
    chk("rstPcWrite", pcWrite, 0);
    chk("rstPcSel", pcSel, 0);
    chk("rstIllegal", illegal, 0);
    chk("rstStackTop", stackTop, 0);
    chk("rstSelectAluArg", selectAluArg, 0);
    chk("rstSelectToWrite", selectToWrite, 0);
    chk("rstAluFunction", ALUfunction, 0);
    releaseReset();

    runInstr({2'b00, 3'b010, 14'h0abc}, 12'h010, 0, 0, 1'b0, 1'b0, 1'b0);

    snap = memReadCycles;
    runInstr({3'b100, 2'b00, 14'h1234}, 12'h011, 1, 2, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    #1;
    chk("ldmMemReadCycles", memReadCycles - snap, 3);

    runInstr({3'b101, 2'b00, 14'h0005}, 12'h012, 0, 0, 1'b1, 1'b0, 1'b0);
    runInstr({3'b101, 2'b00, 14'h0005}, 12'h013, 0, 0, 1'b0, 1'b1, 1'b0);
    runInstr({3'b100, 2'b01, 14'h0777}, 12'h014, 0, 1, 1'b0, 1'b0, 1'b0);

    snap = illegalPulses;
    runInstr({3'b100, 2'b11, 14'h0042}, 12'h015, 0, 0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    #1;
    chk("illegal10011Pulses", illegalPulses - snap, 1);

    snap = illegalPulses;
    for (int k = 0; k < 9; k++)
      runInstr({3'b111, 2'b01, 14'($urandom)}, 12'd5, 0, 0, 1'b0, 1'b0, 1'b0);
    runInstr({3'b111, 2'b10, 14'h0000}, 12'h200, 0, 0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    #1;
`ifdef CALL_STACK_EN
    chk("jsbOverflowPulses", illegalPulses - snap, 1);
    chk("stackDepthAfterRet", stk.size(), 7);
`else
    chk("jsbRetNoStackPulses", illegalPulses - snap, 10);
`endif

    for (int n = 0; n < 250; n++) begin
      w = 19'($urandom);
      runInstr(w, PC_W'($urandom), $urandom_range(0, 2), $urandom_range(0, 3),
               1'($urandom), 1'($urandom), 1'b0);
    end

    runInstr({3'b100, 2'b00, 14'h0101}, 12'h0ff, 0, 0, 1'b0, 1'b0, 1'b1);
    @(posedge clock);
    #1;
    memAck = 1'b0;
    chk("preAbortMemRead", memRead, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("abortMemRead", memRead, 0);
    chk("abortState", state, 0);
    chk("abortInstrReq", instrReq, 0);
    @(posedge clock);
    #1;
    chk("resetHoldState", state, 0);
    releaseReset();

    for (int n = 0; n < 30; n++) begin
      w = 19'($urandom);
      runInstr(w, PC_W'($urandom), $urandom_range(0, 2), $urandom_range(0, 3),
               1'($urandom), 1'($urandom), 1'b0);
    end
    @(negedge clock);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
